vga_score_counter: RTL

Keeps the game score as a saturating binary count and converts it to three BCD digits with a sequential double-dabble engine. Updates the displayed digits only at frame boundaries, so a digit never changes mid-frame. Sits directly upstream of the per-digit seven-segment renderers in the VGA overlay: each `digitN` output drives one renderer's 4-bit digit input. Inputs come from the snake game logic (`eat`, `clear`) and the VGA timing generator (`frame_start`).

---
 rtl/vga_score_pkg.sv | 23 ++
 rtl/bin2bcd_seq.sv | 77 +++++++
 rtl/vga_score_counter.sv | 114 +++++++++++
 3 files changed

// File: rtl/vga_score_pkg.sv
// Shared types for the score counter: BCD digit triple, converter state, dabble helper.
package vga_score_pkg;

  localparam int MAX_BCD_DIGITS = 3;

  typedef struct packed {
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd3_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } conv_state_t;

  function automatic logic [3:0] dabble_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one LOAD cycle, W SHIFT cycles, one DONE cycle.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_LOAD  | snapshot binary input, clear accumulator
//   ST_SHIFT | adjust nibbles >= 5 by +3, then shift {acc, sr} left
//   ST_DONE  | publish accumulator to bcd, return to idle
module bin2bcd_seq
  import vga_score_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         done,
  output logic         busy,
  output logic [W-1:0] bin_snap,
  output bcd3_t        bcd
);

  localparam int CNT_W = $clog2(W + 1);
  localparam int ACC_W = 4 * MAX_BCD_DIGITS;

  conv_state_t      state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     sr;
  logic [ACC_W-1:0] acc, acc_adj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_SHIFT;
      ST_SHIFT: if (cnt == '0) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign acc_adj = {dabble_adj(acc[11:8]), dabble_adj(acc[7:4]), dabble_adj(acc[3:0])};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      sr       <= '0;
      acc      <= '0;
      bin_snap <= '0;
      bcd      <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          sr       <= bin;
          bin_snap <= bin;
          acc      <= '0;
          cnt      <= CNT_W'(W - 1);
        end
        ST_SHIFT: begin
          acc <= {acc_adj[ACC_W-2:0], sr[W-1]};
          sr  <= {sr[W-2:0], 1'b0};
          cnt <= cnt - 1'b1;
        end
        ST_DONE: bcd <= bcd3_t'(acc);
        default: ;
      endcase
    end
  end

  assign done = (state == ST_DONE);
  assign busy = (state != ST_IDLE);

endmodule

// File: rtl/vga_score_counter.sv
// Saturating game score with frame-synchronous BCD display.
// Optional high-score tracking enabled by defining SCORE_HISCORE_EN.
module vga_score_counter
  import vga_score_pkg::*;
#(
  parameter int SCORE_W   = 10,
  parameter int MAX_SCORE = 999,
  parameter int INC       = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       eat,
  input  logic       clear,
  input  logic       frame_start,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       busy,
  output logic       saturated,
  output logic [3:0] hi_digit2,
  output logic [3:0] hi_digit1,
  output logic [3:0] hi_digit0
);

  localparam logic [SCORE_W:0] MAX_EXT = (SCORE_W + 1)'(MAX_SCORE);
  localparam logic [SCORE_W:0] INC_EXT = (SCORE_W + 1)'(INC);

  logic [SCORE_W-1:0] score, score_next, conv_snap;
  logic [SCORE_W:0]   sum;
  logic               conv_req, conv_start, conv_busy, conv_done;
  bcd3_t              conv_bcd, disp;

  assign sum = {1'b0, score} + INC_EXT;

  always_comb begin
    score_next = score;
    if (clear)    score_next = '0;
    else if (eat) score_next = (sum > MAX_EXT) ? MAX_EXT[SCORE_W-1:0] : sum[SCORE_W-1:0];
  end

  assign conv_start = conv_req & ~conv_busy;

  // A change landing on the start edge keeps the request alive: requests coalesce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score    <= '0;
      conv_req <= 1'b0;
      disp     <= '0;
    end else begin
      score    <= score_next;
      conv_req <= (score_next != score) | (conv_req & ~conv_start);
      if (frame_start) disp <= conv_bcd;
    end
  end

  bin2bcd_seq #(.W(SCORE_W)) u_conv (
    .clk      (clk),
    .rst      (reset),
    .start    (conv_start),
    .bin      (score),
    .done     (conv_done),
    .busy     (conv_busy),
    .bin_snap (conv_snap),
    .bcd      (conv_bcd)
  );

  assign digit2    = disp.d2;
  assign digit1    = disp.d1;
  assign digit0    = disp.d0;
  assign busy      = conv_busy | conv_req;
  assign saturated = (score == MAX_EXT[SCORE_W-1:0]);

`ifdef SCORE_HISCORE_EN
  logic [SCORE_W-1:0] last_conv, hi_score, hi_cand;
  bcd3_t              hi_cand_bcd, hi_bcd, hi_disp;
  logic               hi_pending;

  // The candidate is captured at clear, while conv_bcd/last_conv still hold the pre-clear result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_conv   <= '0;
      hi_score    <= '0;
      hi_cand     <= '0;
      hi_cand_bcd <= '0;
      hi_bcd      <= '0;
      hi_disp     <= '0;
      hi_pending  <= 1'b0;
    end else begin
      if (conv_done) last_conv <= conv_snap;
      if (clear && (last_conv > hi_score)) begin
        hi_pending  <= 1'b1;
        hi_cand     <= last_conv;
        hi_cand_bcd <= conv_bcd;
      end else if (hi_pending && !conv_busy && !conv_req) begin
        hi_pending <= 1'b0;
        hi_score   <= hi_cand;
        hi_bcd     <= hi_cand_bcd;
      end
      if (frame_start) hi_disp <= hi_bcd;
    end
  end

  assign hi_digit2 = hi_disp.d2;
  assign hi_digit1 = hi_disp.d1;
  assign hi_digit0 = hi_disp.d0;
`else
  logic unused_hi;
  assign unused_hi = ^{conv_done, conv_snap};
  assign hi_digit2 = 4'd0;
  assign hi_digit1 = 4'd0;
  assign hi_digit0 = 4'd0;
`endif

endmodule
